uart_tx_fifo: RTL and testbench

Parametrised, single-clock UART transmitter with an integrated transmit FIFO and an internal baud-rate divider. Successor to the two-clock UART transmitter: it removes the separate UART clock and its clock-domain-crossing registers, and generalises word length, stop bits and buffering. It sits between 100 MHz producer logic and the RS232 peripheral pin. Producers push words through a valid/ready handshake, and the block serialises them LSB-first.

---
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock UART transmitter (LSB-first) with a transmit FIFO and baud divider.
// Optional parity bit between data and stop bits: compile with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset_b,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [CW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level;
  logic                   full, empty, push, pop, load, baud_end;
  logic [DATA_BITS-1:0]   rd_data;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign push     = tx_valid && !full;
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: load = !empty;
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == CW'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + CW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == CW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = IDLE;
            load    = !empty;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    // A load overrides the IDLE decision so the next start bit follows the stop bit directly.
    if (load) begin
      shift_d = rd_data;
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = (^rd_data) ^ (PARITY_ODD != 0);
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx_ready    = !full;
  assign tx_busy     = (state_q != IDLE);
  assign fifo_level  = level;
  assign tx_data_out = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1/odd-parity instance (A) and 7-bit, 2-stop instance (B).
module tb_uart_tx_fifo;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int FA = (1 + 8 + PE + 1) * CPB;
  localparam int FB = (1 + 7 + PE + 2) * CPB;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_busy, a_line;
  logic [7:0] a_data;
  logic [2:0] a_level;
  logic       b_valid, b_ready, b_busy, b_line;
  logic [6:0] b_data;
  logic [2:0] b_level;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)) u_a (
    .clk(clk), .reset_b(reset_b), .tx_valid(a_valid), .tx_data(a_data), .tx_ready(a_ready),
    .tx_busy(a_busy), .fifo_level(a_level), .tx_data_out(a_line));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset_b(reset_b), .tx_valid(b_valid), .tx_data(b_data), .tx_ready(b_ready),
    .tx_busy(b_busy), .fifo_level(b_level), .tx_data_out(b_line));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level at bit slot idx of a frame: start, data LSB-first, optional parity, stop.
  function automatic logic exp_line(input logic [8:0] d, input int nb, input bit odd, input int idx);
    logic p;
    p = odd;
    for (int i = 0; i < nb; i++) p ^= d[i];
    if (idx == 0) return 1'b0;
    if (idx <= nb) return d[idx-1];
    if (PE == 1 && idx == nb + 1) return p;
    return 1'b1;
  endfunction

  // Push one or two words on consecutive edges into idle instance A and check every line cycle.
  task automatic stream_a(input logic [7:0] w0, input logic [7:0] w1, input int n, input string tag);
    logic [7:0] w;
    logic       e;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = w0;
    @(posedge clk); #1;
    check_eq({tag, "_lvl0"}, a_level, 1);
    check_eq({tag, "_busy0"}, a_busy, 0);
    @(negedge clk);
    if (n == 2) a_data = w1;
    else a_valid = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check_eq({tag, "_lvl1"}, a_level, n - 1);
    for (int j = 0; j <= n * FA; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      w = (j / FA == 0) ? w0 : w1;
      e = (j < n * FA) ? exp_line({1'b0, w}, 8, 1'b1, (j % FA) / CPB) : 1'b1;
      check_eq($sformatf("%s_line%0d", tag, j), a_line, e);
      check_eq($sformatf("%s_busy%0d", tag, j), a_busy, (j < n * FA) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int lows;
    logic e;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_line", a_line, 1);
    check_eq("rst_a_ready", a_ready, 1);
    check_eq("rst_a_busy", a_busy, 0);
    check_eq("rst_a_level", a_level, 0);
    check_eq("rst_b_line", b_line, 1);
    check_eq("rst_b_level", b_level, 0);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_a_busy", a_busy, 0);

    // Single frame 0xA5, then two back-to-back frames with no idle gap.
    stream_a(8'hA5, 8'h00, 1, "a5");
    stream_a(8'h3C, 8'hC3, 2, "b2b");

    // Fill: 0x01..0x05 accepted, 0x06 refused while full.
    for (int w = 1; w <= 5; w++) begin
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = 8'(w);
      check_eq($sformatf("fill_rdy%0d", w), a_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    a_data = 8'h06;
    check_eq("fill_rdy6", a_ready, 0);
    check_eq("fill_lvl", a_level, 4);
    @(posedge clk); #1;
    check_eq("fill_lvl_hold", a_level, 4);
    a_valid = 1'b0;
    k = 0;
    while (k < 3 * FA) begin
      @(posedge clk); #1;
      k++;
      if (a_ready) break;
    end
    check_eq("fill_rdy_rise", k, FA - 4);
    check_eq("fill_lvl_pop", a_level, 3);
    k = 0;
    while (k < 6 * FA) begin
      @(posedge clk); #1;
      k++;
      if (!a_busy) break;
    end
    check_eq("fill_drain", k, 4 * FA);
    check_eq("fill_empty", a_level, 0);

    // Instance B: 7 data bits, 2 stop bits, word 0x7F.
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = 7'h7F;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check_eq("b_lvl0", b_level, 1);
    @(posedge clk); #1;
    for (int j = 0; j <= FB; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      e = (j < FB) ? exp_line(9'h07F, 7, 1'b0, j / CPB) : 1'b1;
      check_eq($sformatf("b_line%0d", j), b_line, e);
      check_eq($sformatf("b_busy%0d", j), b_busy, (j < FB) ? 1 : 0);
    end

    // Reset during the third data bit with two words still queued.
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h11;
    @(posedge clk);
    @(negedge clk);
    a_data = 8'h22;
    @(posedge clk);
    @(negedge clk);
    a_data = 8'h33;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("prerst_line", a_line, 0);
    check_eq("prerst_lvl", a_level, 2);
    #2;
    reset_b = 1'b0;
    #1;
    check_eq("rst_mid_line", a_line, 1);
    check_eq("rst_mid_lvl", a_level, 0);
    check_eq("rst_mid_ready", a_ready, 1);
    check_eq("rst_mid_busy", a_busy, 0);
    @(negedge clk);
    reset_b = 1'b1;
    lows = 0;
    for (int j = 0; j < 3 * FA; j++) begin
      @(posedge clk); #1;
      if (!a_line || a_busy) lows++;
    end
    check_eq("post_rst_quiet", lows, 0);
    check_eq("post_rst_lvl", a_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
